// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store engine between the control
// unit and a request/response memory port. Holds the MAR/MDR, lane-aligns
// byte stores, zero-extends byte loads and flags misaligned word accesses.
//
// Ports:
//   clk, reset_n                  clock (rising edge), async active-low reset
//   req_valid/req_ready           request handshake (ready only in IDLE)
//   req_write, req_byte           store/load, byte/word
//   req_addr, req_wdata           byte address, store data (byte store: [7:0])
//   mem_address, mem_wdata        registered MAR / MDR
//   mem_byte_enable               active lanes
//   mem_read, mem_write           strobes, held high until mem_resp
//   mem_rdata, mem_resp           memory completion and read data
//   rsp_valid, rsp_rdata          one-cycle response, load result
//   rsp_error                     misaligned access or timeout
//
// Optional feature: define MEM_TIMEOUT_EN to abort an access that has waited
// TIMEOUT_CYCLES cycles without mem_resp.
module mem_access_unit #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic                    req_byte,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
  output logic                    mem_read,
  output logic                    mem_write,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_resp,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_error
);

  localparam int unsigned BE_W   = DATA_WIDTH / 8;
  localparam int unsigned LANE_W = $clog2(BE_W);

  // Elaboration-time parameter sanity.
  if (DATA_WIDTH < 16 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0) begin : g_bad_dw
    $error("mem_access_unit: DATA_WIDTH must be a power of 2 and >= 16");
  end
  if (TIMEOUT_CYCLES == 0) begin : g_bad_to
    $error("mem_access_unit: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] mar_q, mar_d;
  logic [DATA_WIDTH-1:0] mdr_q, mdr_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [BE_W-1:0]       be_q, be_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic                  is_byte_q, is_byte_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_error_q, rsp_error_d;
  logic                  ready_q, ready_d;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Lane of the incoming request and of the access in flight.
  logic [LANE_W-1:0]     req_lane;
  logic [LANE_W-1:0]     mar_lane;
  logic [7:0]            lane_byte;
  logic [DATA_WIDTH-1:0] load_data;

  assign req_lane  = req_addr[LANE_W-1:0];
  assign mar_lane  = mar_q[LANE_W-1:0];
  assign lane_byte = 8'(mem_rdata >> {mar_lane, 3'b000});
  assign load_data = is_byte_q ? DATA_WIDTH'(lane_byte) : mem_rdata;

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    mar_d       = mar_q;
    mdr_d       = mdr_q;
    be_d        = be_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    is_byte_d   = is_byte_q;
    rsp_valid_d = 1'b0;
    rsp_error_d = 1'b0;
    rsp_rdata_d = '0;
`ifdef MEM_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          mar_d     = req_addr;
          is_byte_d = req_byte;
          if (req_byte) begin
            be_d  = BE_W'(1) << req_lane;
            mdr_d = {BE_W{req_wdata[7:0]}};
          end else begin
            be_d  = '1;
            mdr_d = req_wdata;
          end
          if (!req_byte && req_lane != '0) begin
            // Misaligned word: answer with an error, never touch memory.
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
          end else begin
            state_d = ACCESS;
            rd_d    = !req_write;
            wr_d    = req_write;
`ifdef MEM_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end

      ACCESS: begin
        if (mem_resp) begin
          state_d     = DONE;
          rd_d        = 1'b0;
          wr_d        = 1'b0;
          rsp_valid_d = 1'b1;
          if (!wr_q) begin
            mdr_d       = load_data;
            rsp_rdata_d = load_data;
          end
`ifdef MEM_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // This cycle would bring the wait count to the limit: abort.
          state_d     = DONE;
          rd_d        = 1'b0;
          wr_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase

    ready_d = (state_d == IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mar_q       <= '0;
      mdr_q       <= '0;
      be_q        <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      is_byte_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
      ready_q     <= 1'b1;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mar_q       <= mar_d;
      mdr_q       <= mdr_d;
      be_q        <= be_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      is_byte_q   <= is_byte_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
      ready_q     <= ready_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign req_ready       = ready_q;
  assign mem_address     = mar_q;
  assign mem_wdata       = mdr_q;
  assign mem_byte_enable = be_q;
  assign mem_read        = rd_q;
  assign mem_write       = wr_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign rsp_error       = rsp_error_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized checks of mem_access_unit
// (16-bit data/address) against a transaction-level reference model.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write, req_byte;
  logic [15:0] req_addr, req_wdata;
  logic [15:0] mem_address, mem_wdata, mem_rdata, rsp_rdata;
  logic [1:0]  mem_byte_enable;
  logic        mem_read, mem_write, mem_resp, rsp_valid, rsp_error;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_access_unit #(
    .DATA_WIDTH(16), .ADDR_WIDTH(16), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_byte_enable(mem_byte_enable), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
  );

  // What one transaction looks like from outside the unit.
  typedef struct {
    int          rd_cyc;
    int          wr_cyc;
    int          lat;
    int          valid_cyc;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] rdata;
    logic        err;
    logic        ready_before;
    logic        ready_after;
    logic        unstable;
  } obs_t;

  // Reference model: expected observation of one transaction.
  function automatic obs_t model(input logic wr, input logic by,
                                 input logic [15:0] addr, input logic [15:0] wd,
                                 input logic [15:0] rd, input int waits);
    obs_t m;
    int   lane;
    int   cyc;
    bit   timed_out;
    lane = int'(addr % 16'd2);
    m.ready_before = 1'b1;
    m.ready_after  = 1'b1;
    m.valid_cyc    = 1;
    m.unstable     = 1'b0;
    m.addr = '0; m.wdata = '0; m.be = '0; m.rdata = '0;
    m.rd_cyc = 0; m.wr_cyc = 0;
    if (!by && lane != 0) begin
      m.lat = 1;
      m.err = 1'b1;
      return m;
    end
    m.addr  = addr;
    m.be    = by ? 2'(1 << lane) : 2'b11;
    m.wdata = by ? {wd[7:0], wd[7:0]} : wd;
    timed_out = 1'b0;
`ifdef MEM_TIMEOUT_EN
    if (waits < 0 || waits >= TO) timed_out = 1'b1;
`endif
    if (timed_out) begin
      cyc     = TO;
      m.lat   = TO + 1;
      m.err   = 1'b1;
      m.rdata = '0;
    end else begin
      cyc     = waits + 1;
      m.lat   = waits + 2;
      m.err   = 1'b0;
      if (wr)      m.rdata = '0;
      else if (by) m.rdata = (rd >> (8 * lane)) & 16'h00FF;
      else         m.rdata = rd;
    end
    m.rd_cyc = wr ? 0 : cyc;
    m.wr_cyc = wr ? cyc : 0;
    return m;
  endfunction

  // Issue one request, play the memory (responds after 'waits' strobe cycles,
  // never if waits < 0) and record what the unit did.
  task automatic run_access(input logic wr, input logic by, input logic [15:0] addr,
                            input logic [15:0] wd, input logic [15:0] rd,
                            input int waits, input logic noise, output obs_t o);
    int wcnt;
    bit seen;
    o.rd_cyc = 0; o.wr_cyc = 0; o.lat = -1; o.valid_cyc = 0;
    o.addr = '0; o.wdata = '0; o.be = '0; o.rdata = '0; o.err = 1'b0;
    o.ready_after = 1'b0; o.unstable = 1'b0;
    @(negedge clk);
    o.ready_before = req_ready;
    req_valid = 1'b1; req_write = wr; req_byte = by;
    req_addr = addr; req_wdata = wd;
    mem_resp = noise;                       // must be ignored in IDLE
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = 16'($urandom);
    req_wdata = 16'($urandom);
    wcnt = 0; seen = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      mem_resp  = 1'b0;
      mem_rdata = 16'($urandom);
      if (mem_read || mem_write) begin
        if (o.rd_cyc + o.wr_cyc == 0) begin
          o.addr = mem_address; o.wdata = mem_wdata; o.be = mem_byte_enable;
        end else if (o.addr !== mem_address || o.wdata !== mem_wdata ||
                     o.be !== mem_byte_enable) begin
          o.unstable = 1'b1;
        end
        if (mem_read)  o.rd_cyc++;
        if (mem_write) o.wr_cyc++;
        if (waits >= 0 && wcnt == waits) begin
          mem_resp = 1'b1; mem_rdata = rd;
        end
        wcnt++;
      end
      if (rsp_valid) begin
        o.valid_cyc++;
        if (!seen) begin
          seen = 1; o.lat = k; o.rdata = rsp_rdata; o.err = rsp_error;
        end
      end else if (seen && k == o.lat + 1) begin
        o.ready_after = req_ready;
      end
      if (seen && k >= o.lat + 2) break;
    end
    mem_resp = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({req_ready, mem_read, mem_write, rsp_valid, rsp_error} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset.ctrl: got %b expected 10000",
               {req_ready, mem_read, mem_write, rsp_valid, rsp_error});
    end
    n_cmp++;
    if ({mem_address, mem_wdata, mem_byte_enable, rsp_rdata} !== 50'd0) begin
      n_fail++;
      $display("FAIL reset.data: addr=%h wdata=%h be=%b rdata=%h expected all 0",
               mem_address, mem_wdata, mem_byte_enable, rsp_rdata);
    end
  endtask

  task automatic test_word_load();
    obs_t o;
    run_access(1'b0, 1'b0, 16'h1234, 16'h0000, 16'hBEEF, 2, 1'b0, o);
    n_cmp++; if (o.rd_cyc !== 3 || o.wr_cyc !== 0) begin n_fail++;
      $display("FAIL word_load.strobe: rd=%0d wr=%0d expected 3/0", o.rd_cyc, o.wr_cyc); end
    n_cmp++; if (o.be !== 2'b11 || o.addr !== 16'h1234) begin n_fail++;
      $display("FAIL word_load.bus: be=%b addr=%h expected 11/1234", o.be, o.addr); end
    n_cmp++; if (o.rdata !== 16'hBEEF || o.err !== 1'b0) begin n_fail++;
      $display("FAIL word_load.rsp: rdata=%h err=%b expected BEEF/0", o.rdata, o.err); end
    n_cmp++; if (o.lat !== 4 || o.valid_cyc !== 1) begin n_fail++;
      $display("FAIL word_load.timing: lat=%0d valid_cyc=%0d expected 4/1", o.lat, o.valid_cyc); end
  endtask

  task automatic test_byte_load();
    obs_t o;
    run_access(1'b0, 1'b1, 16'h0101, 16'h0000, 16'hA5C3, 0, 1'b0, o);
    n_cmp++; if (o.be !== 2'b10) begin n_fail++;
      $display("FAIL byte_load.be: got %b expected 10", o.be); end
    n_cmp++; if (o.rdata !== 16'h00A5) begin n_fail++;
      $display("FAIL byte_load.rdata: got %h expected 00a5", o.rdata); end
    n_cmp++; if (o.lat !== 2 || o.rd_cyc !== 1) begin n_fail++;
      $display("FAIL byte_load.timing: lat=%0d rd=%0d expected 2/1", o.lat, o.rd_cyc); end
  endtask

  task automatic test_byte_store();
    obs_t o;
    run_access(1'b1, 1'b1, 16'h0100, 16'h1277, 16'hFFFF, 1, 1'b0, o);
    n_cmp++; if (o.wdata !== 16'h7777 || o.be !== 2'b01) begin n_fail++;
      $display("FAIL byte_store.bus: wdata=%h be=%b expected 7777/01", o.wdata, o.be); end
    n_cmp++; if (o.wr_cyc !== 2 || o.rd_cyc !== 0) begin n_fail++;
      $display("FAIL byte_store.strobe: wr=%0d rd=%0d expected 2/0", o.wr_cyc, o.rd_cyc); end
    n_cmp++; if (o.rdata !== 16'h0000 || o.err !== 1'b0 || o.lat !== 3) begin n_fail++;
      $display("FAIL byte_store.rsp: rdata=%h err=%b lat=%0d expected 0000/0/3",
               o.rdata, o.err, o.lat); end
  endtask

  task automatic test_misaligned();
    obs_t o;
    run_access(1'b1, 1'b0, 16'h0003, 16'h5A5A, 16'h0000, 0, 1'b0, o);
    n_cmp++; if (o.rd_cyc + o.wr_cyc !== 0) begin n_fail++;
      $display("FAIL misaligned.strobe: got %0d strobe cycles expected 0", o.rd_cyc + o.wr_cyc); end
    n_cmp++; if (o.lat !== 1 || o.err !== 1'b1 || o.valid_cyc !== 1) begin n_fail++;
      $display("FAIL misaligned.rsp: lat=%0d err=%b valid_cyc=%0d expected 1/1/1",
               o.lat, o.err, o.valid_cyc); end
    n_cmp++; if (o.ready_after !== 1'b1 || o.rdata !== 16'h0000) begin n_fail++;
      $display("FAIL misaligned.after: ready=%b rdata=%h expected 1/0000",
               o.ready_after, o.rdata); end
  endtask

  task automatic test_reset_mid_access();
    obs_t o;
    logic [15:0] rd;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0;
    req_addr = 16'h2468; req_wdata = 16'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_read !== 1'b1) begin n_fail++;
      $display("FAIL rst_mid.pre: mem_read=%b expected 1", mem_read); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({mem_read, mem_write, rsp_valid, rsp_error, mem_byte_enable,
         mem_address, mem_wdata, rsp_rdata} !== 54'd0) begin
      n_fail++;
      $display("FAIL rst_mid.async: rd=%b wr=%b v=%b e=%b be=%b addr=%h wd=%h rdata=%h expected all 0",
               mem_read, mem_write, rsp_valid, rsp_error, mem_byte_enable,
               mem_address, mem_wdata, rsp_rdata);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rd = 16'($urandom);
    run_access(1'b0, 1'b0, 16'h0000, 16'h0, rd, 1, 1'b0, o);
    n_cmp++; if (o.rdata !== rd || o.err !== 1'b0 || o.lat !== 3 || o.rd_cyc !== 2) begin
      n_fail++;
      $display("FAIL rst_mid.after: rdata=%h err=%b lat=%0d rd=%0d expected %h/0/3/2",
               o.rdata, o.err, o.lat, o.rd_cyc, rd); end
  endtask

  // Requester holds req_valid: a new request waits for an IDLE cycle.
  task automatic test_back_to_back();
    logic [3:0] v4, r4;
    logic [5:0] v6, r6;
    logic       rdata_ok;
    v4 = '0; r4 = '0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_addr = 16'h0011;
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      v4 = {v4[2:0], rsp_valid};
      r4 = {r4[2:0], req_ready};
    end
    req_valid = 1'b0;
    n_cmp++; if (v4 !== 4'b1010 || r4 !== 4'b0101) begin n_fail++;
      $display("FAIL b2b_misaligned: valid=%b ready=%b expected 1010/0101", v4, r4); end

    v6 = '0; r6 = '0; rdata_ok = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 16'h0ABC; mem_resp = 1'b1; mem_rdata = 16'hC0DE;
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      v6 = {v6[4:0], rsp_valid};
      r6 = {r6[4:0], req_ready};
      if (rsp_valid && rsp_rdata !== 16'hC0DE) rdata_ok = 1'b0;
    end
    req_valid = 1'b0; mem_resp = 1'b0;
    n_cmp++; if (v6 !== 6'b010010 || r6 !== 6'b001001) begin n_fail++;
      $display("FAIL b2b_load: valid=%b ready=%b expected 010010/001001", v6, r6); end
    n_cmp++; if (rdata_ok !== 1'b1) begin n_fail++;
      $display("FAIL b2b_load.rdata: a response did not carry c0de"); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_long_wait();
    obs_t o, m;
    int   w;
`ifdef MEM_TIMEOUT_EN
    w = -1;
`else
    w = 10;
`endif
    run_access(1'b0, 1'b0, 16'h0040, 16'h0, 16'h1357, w, 1'b0, o);
    m = model(1'b0, 1'b0, 16'h0040, 16'h0, 16'h1357, w);
    n_cmp++; if (o.rd_cyc !== m.rd_cyc || o.lat !== m.lat) begin n_fail++;
      $display("FAIL long_wait.timing: rd=%0d lat=%0d expected %0d/%0d",
               o.rd_cyc, o.lat, m.rd_cyc, m.lat); end
    n_cmp++; if (o.err !== m.err || o.rdata !== m.rdata || o.valid_cyc !== 1) begin n_fail++;
      $display("FAIL long_wait.rsp: err=%b rdata=%h vc=%0d expected %b/%h/1",
               o.err, o.rdata, o.valid_cyc, m.err, m.rdata); end
    // Response arriving on the last permitted wait cycle completes normally.
    run_access(1'b0, 1'b0, 16'h0042, 16'h0, 16'h2468, TO - 1, 1'b0, o);
    n_cmp++; if (o.err !== 1'b0 || o.rdata !== 16'h2468 || o.lat !== TO + 1) begin n_fail++;
      $display("FAIL limit_resp: err=%b rdata=%h lat=%0d expected 0/2468/%0d",
               o.err, o.rdata, o.lat, TO + 1); end
  endtask

  task automatic test_random();
    obs_t        o, m;
    logic        wr, by, noise;
    logic [15:0] addr, wd, rd;
    int          waits;
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom); by = 1'($urandom); noise = 1'($urandom);
      addr = 16'($urandom); wd = 16'($urandom); rd = 16'($urandom);
      waits = int'($urandom_range(0, TO - 1));
      run_access(wr, by, addr, wd, rd, waits, noise, o);
      m = model(wr, by, addr, wd, rd, waits);
      n_cmp++; if (o.rd_cyc !== m.rd_cyc || o.wr_cyc !== m.wr_cyc) begin n_fail++;
        $display("FAIL rand[%0d].strobe: rd=%0d wr=%0d expected %0d/%0d",
                 i, o.rd_cyc, o.wr_cyc, m.rd_cyc, m.wr_cyc); end
      n_cmp++; if (o.addr !== m.addr || o.wdata !== m.wdata || o.be !== m.be ||
                   o.unstable !== 1'b0) begin n_fail++;
        $display("FAIL rand[%0d].bus: addr=%h wd=%h be=%b unstable=%b expected %h/%h/%b/0",
                 i, o.addr, o.wdata, o.be, o.unstable, m.addr, m.wdata, m.be); end
      n_cmp++; if (o.rdata !== m.rdata || o.err !== m.err) begin n_fail++;
        $display("FAIL rand[%0d].rsp: rdata=%h err=%b expected %h/%b",
                 i, o.rdata, o.err, m.rdata, m.err); end
      n_cmp++; if (o.lat !== m.lat || o.valid_cyc !== m.valid_cyc ||
                   o.ready_before !== m.ready_before || o.ready_after !== m.ready_after) begin
        n_fail++;
        $display("FAIL rand[%0d].timing: lat=%0d vc=%0d rb=%b ra=%b expected %0d/%0d/1/1",
                 i, o.lat, o.valid_cyc, o.ready_before, o.ready_after, m.lat, m.valid_cyc); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
    req_addr = '0; req_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_word_load();
    test_byte_load();
    test_byte_store();
    test_misaligned();
    test_reset_mid_access();
    test_back_to_back();
    test_long_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
